// File: rtl/swt_pkg.sv
// swt_pkg: shared sizing defaults for the switch debouncer
package swt_pkg;
  localparam int SWT_WIDTH = 4;
  localparam int SWT_DEBOUNCE_CYCLES = 1000000;
  localparam int SWT_SIM_DEBOUNCE_CYCLES = 8;
endpackage

// File: rtl/swt_db_cell.sv
// swt_db_cell: one-bit synchronizer, stability counter and debounced level; edge pulses when SWT_EDGE_EN is defined
module swt_db_cell
  import swt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SWT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic swt_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic cnt_nz_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, flip;
  // a full run of disagreeing samples flips the level; any agreement restarts the run
  always_comb begin
    flip = (sync_q[1] != stable_q) && (cnt_q == LAST);
    cnt_d = (sync_q[1] == stable_q || flip) ? '0 : cnt_q + CW'(1);
    stable_d = stable_q ^ flip;
  end
  // synchronizer, counter and stable level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], swt_i};
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  assign db_o = stable_q;
  assign cnt_nz_o = cnt_d != '0;
`ifdef SWT_EDGE_EN
  logic rise_q, fall_q;
  // pulses registered on the flipping edge so they line up with db_o
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= flip & ~stable_q;
      fall_q <= flip & stable_q;
    end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/swt_debounce.sv
// swt_debounce: WIDTH independent switch debouncers with busy flag; swt_rise/swt_fall active only with SWT_EDGE_EN
module swt_debounce
  import swt_pkg::*;
#(
  parameter int WIDTH = SWT_WIDTH,
  parameter int DEBOUNCE_CYCLES = SWT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_db,
  output logic [WIDTH-1:0] swt_rise,
  output logic [WIDTH-1:0] swt_fall,
  output logic             swt_busy
);
  logic [WIDTH-1:0] cnt_nz;
  logic busy_q, busy_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    swt_db_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(clk),
      .rst(rst),
      .swt_i(swt[i]),
      .db_o(swt_db[i]),
      .rise_o(swt_rise[i]),
      .fall_o(swt_fall[i]),
      .cnt_nz_o(cnt_nz[i])
    );
  end
  // any channel mid-count
  always_comb busy_d = |cnt_nz;
  // busy registered alongside the counters it summarises
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= 1'b0;
    else busy_q <= busy_d;
  assign swt_busy = busy_q;
endmodule

// File: doc/swt_debounce.md
SWT_DEBOUNCE -- requirements
Module: swt_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count before accepting a level change (10 ms at 100 MHz); legal range >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port swt  input  WIDTH  raw asynchronous switch levels.
REQ-006 SHALL have port swt_db  output  WIDTH  debounced, clk-synchronous switch levels.
REQ-007 SHALL have port swt_rise  output  WIDTH  one-cycle pulse per bit on swt_db 0->1.
REQ-008 SHALL have port swt_fall  output  WIDTH  one-cycle pulse per bit on swt_db 1->0.
REQ-009 SHALL have port swt_busy  output  1  high while any channel counter is non-zero.

Function
REQ-010 SHALL pass each swt bit through a two-flop synchronizer; the second-stage value (sync) is the only value the debounce logic uses.
REQ-011 SHALL keep per bit a counter of width $clog2(DEBOUNCE_CYCLES) and a stable bit driving swt_db.
REQ-012 SHALL, per bit, each cycle: sync == stable -> counter cleared to 0; sync != stable and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-013 SHALL, when sync != stable and counter == DEBOUNCE_CYCLES-1, invert stable and clear counter on that edge.
REQ-014 SHALL give latency from a clean swt edge to swt_db change of exactly 2 + DEBOUNCE_CYCLES clk edges.
REQ-015 SHALL reject any disagreement shorter than DEBOUNCE_CYCLES consecutive cycles; a single matching sample restarts the count from 0.
REQ-016 SHALL register swt_rise/swt_fall on the same edge stable flips, so each pulse is coincident with the swt_db transition and high exactly one cycle.
REQ-017 SHALL treat channels independently; simultaneous changes on several bits update in the same cycle with no interaction.
REQ-018 SHALL drive swt_busy as the registered OR of all per-bit "counter non-zero" conditions.
REQ-019 SHALL never assert swt_rise[i] and swt_fall[i] in the same cycle.

Reset
REQ-020 SHALL, while rst is high, force synchronizer flops, counters, swt_db, swt_rise, swt_fall and swt_busy to 0, independent of clk.
REQ-021 SHALL, when rst asserts mid-count, discard partial counts; after release a full 2 + DEBOUNCE_CYCLES is required for any change.
REQ-022 SHALL, after release with a switch already high, report it as a normal 0->1 transition including a swt_rise pulse.

Configuration
REQ-023 SHALL, with macro SWT_EDGE_EN defined, implement swt_rise/swt_fall per REQ-016.
REQ-024 SHALL, without SWT_EDGE_EN, keep swt_rise/swt_fall ports present but tied to 0, with no edge registers synthesized; all other behaviour unchanged.

Structure
REQ-025 SHALL place the DEBOUNCE_CYCLES default, the simulation value 8 and the WIDTH default in a shared package swt_pkg.
REQ-026 SHALL implement one sub-module swt_db_cell (synchronizer, counter, stable bit, edge pulses for one bit), instantiated WIDTH times by generate.

Verification (DEBOUNCE_CYCLES = 8, WIDTH = 4)
REQ-027 SHALL check reset: swt=4'hF held through rst -> all outputs 0 during rst; swt_db=4'hF exactly 10 edges after release, swt_rise=4'hF for one cycle.
REQ-028 SHALL check glitch rejection: swt[0] high for 5 cycles then low -> swt_db stays 0, no pulses, swt_busy high then back to 0.
REQ-029 SHALL check bounce: swt[1] toggled every 3 cycles for 24 cycles then held 1 -> swt_db[1] rises exactly 10 edges after final toggle, exactly one swt_rise[1] pulse.
REQ-030 SHALL check simultaneous bits: from swt_db=4'b1000, swt changes to 4'b0100 in one cycle -> same-cycle update to 4'b0100, swt_rise=4'b0100, swt_fall=4'b1000 for one cycle.
REQ-031 SHALL check reset mid-count: rst pulsed when the swt[2] counter reaches 5 -> counter 0, and swt_db[2] updates 10 edges after release, not earlier.
REQ-032 SHALL check config: build without SWT_EDGE_EN, rerun REQ-027 -> swt_db identical, swt_rise/swt_fall constantly 0.
